// File: rtl/sm4_pkg.sv
// SM4 shared constants: system parameters FK, CK generator, S-box and key-expansion FSM states.
// Latency: n/a (package of constants and pure functions).
// Backpressure: n/a.
package sm4_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        FIN    = 2'd2
    } sm4_state_e;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // Byte substitution shared with the round engine.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // CK[i] byte j (j=0 is the MSB) = (4i+j)*7, truncated to 8 bits.
    function automatic logic [31:0] ck(input logic [4:0] i);
        logic [31:0] r;
        logic [7:0]  base;
        logic [7:0]  b;
        r    = '0;
        base = {1'b0, i, 2'b00};
        for (int j = 0; j < 4; j++) begin
            b = (base + 8'(j)) * 8'd7;
            r[31-8*j -: 8] = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/sm4_key_tprime.sv
// Key-schedule transform T': byte-wise S-box followed by B ^ rol(B,13) ^ rol(B,23).
// Latency: purely combinational.
// Backpressure: none.
module sm4_key_tprime
    import sm4_pkg::*;
(
    input  logic [31:0] x_i,
    output logic [31:0] y_o
);

    logic [31:0] b;

    assign b   = {sbox(x_i[31:24]), sbox(x_i[23:16]), sbox(x_i[15:8]), sbox(x_i[7:0])};
    assign y_o = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};

endmodule

// File: rtl/sm4_key_expand.sv
// Expands a 128-bit SM4 master key into rk0..rk31, writing rk_i to round-key RAM address i.
// Latency: start accepted at E0, rk0 written after E1, rk31 after E32, done pulse after E33.
// Backpressure: none; the RAM takes one write per cycle and start is ignored unless IDLE.
module sm4_key_expand
    import sm4_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    output logic         wr_en,
    output logic [4:0]   wraddr,
    output logic [31:0]  wrdata
);

    sm4_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] k0_q, k1_q, k2_q, k3_q;
    logic [31:0] k0_d, k1_d, k2_d, k3_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        kv_q, kv_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wraddr_q, wraddr_d;
    logic [31:0] wrdata_q, wrdata_d;

    logic [31:0] tp_in;
    logic [31:0] tp_out;
    logic [31:0] rk;

    // Round key for the current counter value; only meaningful in EXPAND.
    assign tp_in = k1_q ^ k2_q ^ k3_q ^ ck(cnt_q);
    assign rk    = k0_q ^ tp_out;

    sm4_key_tprime u_tprime (
        .x_i (tp_in),
        .y_o (tp_out)
    );

    // State, key window, counter and registered outputs; async clear on rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            k0_q     <= '0;
            k1_q     <= '0;
            k2_q     <= '0;
            k3_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            kv_q     <= 1'b0;
            wr_en_q  <= 1'b0;
            wraddr_q <= '0;
            wrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k0_q     <= k0_d;
            k1_q     <= k1_d;
            k2_q     <= k2_d;
            k3_q     <= k3_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            kv_q     <= kv_d;
            wr_en_q  <= wr_en_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
        end
    end

    // Next-state: accept in IDLE, slide the key window in EXPAND, publish completion in FIN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k0_d     = k0_q;
        k1_d     = k1_q;
        k2_d     = k2_q;
        k3_d     = k3_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        kv_d     = kv_q;
        wr_en_d  = 1'b0;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k0_d    = key[127:96] ^ FK0;
                    k1_d    = key[95:64]  ^ FK1;
                    k2_d    = key[63:32]  ^ FK2;
                    k3_d    = key[31:0]   ^ FK3;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    kv_d    = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                wr_en_d  = 1'b1;
                wraddr_d = cnt_q;
                wrdata_d = rk;
                k0_d     = k1_q;
                k1_d     = k2_q;
                k2_d     = k3_q;
                k3_d     = rk;
                cnt_d    = cnt_q + 5'd1;
                // Leave explicitly on the last round rather than relying on the 5-bit wrap.
                if (cnt_q == 5'd31) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                kv_d    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = kv_q;
    assign wr_en     = wr_en_q;
    assign wraddr    = wraddr_q;
    assign wrdata    = wrdata_q;

endmodule

// File: tb/tb_sm4_key_expand.sv
// Directed bench for sm4_key_expand: captures RAM writes and checks timing and key schedules.
// Latency: checks done 33 edges after acceptance and rk0 written after the first EXPAND edge.
// Backpressure: none; the bench RAM absorbs every write.
module tb_sm4_key_expand;
    import sm4_pkg::*;

    localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] ALT_KEY = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] PT      = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] CT      = 128'h681EDF34D206965E86B3E94F536E4246;
    localparam logic [31:0]  TB_FK0  = 32'hA3B1BAC6;
    localparam logic [31:0]  TB_FK1  = 32'h56AA3350;
    localparam logic [31:0]  TB_FK2  = 32'h677D9197;
    localparam logic [31:0]  TB_FK3  = 32'hB27022DC;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         key_valid;
    logic         wr_en;
    logic [4:0]   wraddr;
    logic [31:0]  wrdata;

    int n_cmp;
    int n_err;

    int          edge_no;
    int          e0;
    logic [31:0] ram [32];
    logic [31:0] exp_rk [32];
    logic [4:0]  exp_addr;
    int          addr_err;
    int          wr_total;
    int          first_wr;
    int          run;
    int          runs;
    int          last_run;
    int          done_cnt;
    int          done_e [4];

    sm4_key_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .wr_en     (wr_en),
        .wraddr    (wraddr),
        .wrdata    (wrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [31:0] tpk(input logic [31:0] x);
        logic [31:0] b;
        b = subw(x);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    function automatic logic [31:0] tenc(input logic [31:0] x);
        logic [31:0] b;
        b = subw(x);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] ck_tb(input int i);
        logic [31:0] r;
        int          v;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            v = ((4 * i + j) * 7) % 256;
            r[31-8*j -: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic build_model(input logic [127:0] k);
        logic [31:0] a0, a1, a2, a3, r;
        a0 = k[127:96] ^ TB_FK0;
        a1 = k[95:64]  ^ TB_FK1;
        a2 = k[63:32]  ^ TB_FK2;
        a3 = k[31:0]   ^ TB_FK3;
        for (int i = 0; i < 32; i++) begin
            r = a0 ^ tpk(a1 ^ a2 ^ a3 ^ ck_tb(i));
            exp_rk[i] = r;
            a0 = a1; a1 = a2; a2 = a3; a3 = r;
        end
    endtask

    // Round engine stand-in: encrypts reading RAM 0..31, decrypts reading 31..0.
    function automatic logic [127:0] crypt(input logic [127:0] din, input bit dec);
        logic [31:0] x0, x1, x2, x3, t, rk;
        x0 = din[127:96]; x1 = din[95:64]; x2 = din[63:32]; x3 = din[31:0];
        for (int i = 0; i < 32; i++) begin
            rk = dec ? ram[31-i] : ram[i];
            t  = x0 ^ tenc(x1 ^ x2 ^ x3 ^ rk);
            x0 = x1; x1 = x2; x2 = x3; x3 = t;
        end
        return {x3, x2, x1, x0};
    endfunction

    task automatic clear_mon();
        exp_addr = '0;
        addr_err = 0;
        wr_total = 0;
        first_wr = 0;
        run      = 0;
        runs     = 0;
        last_run = 0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) done_e[i] = 0;
        for (int i = 0; i < 32; i++) ram[i] = '0;
    endtask

    // One clock: pass the rising edge, then sample outputs on the falling edge.
    task automatic tick();
        @(posedge clk);
        edge_no++;
        @(negedge clk);
        if (wr_en) begin
            ram[wraddr] = wrdata;
            if (wraddr != exp_addr) addr_err++;
            exp_addr = exp_addr + 5'd1;
            if (wr_total == 0) first_wr = edge_no;
            wr_total++;
            run++;
        end else if (run > 0) begin
            runs++;
            last_run = run;
            run = 0;
        end
        if (done) begin
            if (done_cnt < 4) done_e[done_cnt] = edge_no;
            done_cnt++;
        end
    endtask

    task automatic start_exp(input logic [127:0] k);
        key   = k;
        start = 1'b1;
        e0    = edge_no + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt < target) check_eq("wait_done_timeout", done_cnt, target);
    endtask

    task automatic check_sched(input string tag);
        for (int i = 0; i < 32; i++) check_eq($sformatf("%s_rk%0d", tag, i), ram[i], exp_rk[i]);
    endtask

    initial begin
        bit kv33;
        bit kv34;
        n_cmp   = 0;
        n_err   = 0;
        edge_no = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        key     = '0;
        kv33    = 1'b0;
        kv34    = 1'b1;
        clear_mon();

        // Reset values
        repeat (3) tick();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_key_valid", key_valid, 1'b0);
        check_eq("rst_wr_en", wr_en, 1'b0);
        check_eq("rst_wraddr", wraddr, 5'd0);
        check_eq("rst_wrdata", wrdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Standard vector: timing and known round keys
        clear_mon();
        build_model(STD_KEY);
        start_exp(STD_KEY);
        check_eq("std_busy_after_e0", busy, 1'b1);
        check_eq("std_wr_en_after_e0", wr_en, 1'b0);
        wait_done(1, 60);
        repeat (3) tick();
        check_eq("std_first_wr_lat", first_wr - e0, 1);
        check_eq("std_done_lat", done_e[0] - e0, 33);
        check_eq("std_done_count", done_cnt, 1);
        check_eq("std_wr_runs", runs, 1);
        check_eq("std_wr_run_len", last_run, 32);
        check_eq("std_addr_err", addr_err, 0);
        check_eq("std_rk0", ram[0], 32'hF12186F9);
        check_eq("std_rk1", ram[1], 32'h41662B61);
        check_eq("std_rk31", ram[31], 32'h9124A012);
        check_eq("std_key_valid", key_valid, 1'b1);
        check_eq("std_busy_idle", busy, 1'b0);
        check_sched("std");

        // End-to-end with the expanded standard key
        check_eq("enc", crypt(PT, 1'b0), CT);
        check_eq("dec", crypt(CT, 1'b1), PT);

        // All-zero key: address sequence and CK[0]
        clear_mon();
        build_model('0);
        start_exp('0);
        wait_done(1, 60);
        check_eq("mk0_wr_total", wr_total, 32);
        check_eq("mk0_addr_err", addr_err, 0);
        check_eq("mk0_rk0", ram[0], TB_FK0 ^ tpk(TB_FK1 ^ TB_FK2 ^ TB_FK3 ^ 32'h00070E15));
        check_sched("mk0");

        // start re-pulsed mid-expansion with another key is ignored
        clear_mon();
        build_model(STD_KEY);
        start_exp(STD_KEY);
        repeat (9) tick();
        key   = ALT_KEY;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, 60);
        repeat (10) tick();
        check_eq("restart_done_count", done_cnt, 1);
        check_eq("restart_wr_total", wr_total, 32);
        check_eq("restart_rk31", ram[31], 32'h9124A012);
        check_sched("restart");

        // start held high: back-to-back expansions
        clear_mon();
        key   = STD_KEY;
        start = 1'b1;
        e0    = edge_no + 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (edge_no - e0 == 33) kv33 = key_valid;
            if (edge_no - e0 == 34) kv34 = key_valid;
        end
        start = 1'b0;
        wait_done(3, 60);
        check_eq("hold_done0", done_e[0] - e0, 33);
        check_eq("hold_done1", done_e[1] - e0, 67);
        check_eq("hold_done2", done_e[2] - e0, 101);
        check_eq("hold_kv_e33", kv33, 1'b1);
        check_eq("hold_kv_e34", kv34, 1'b0);
        check_eq("hold_runs", runs, 3);
        check_eq("hold_wr_total", wr_total, 96);
        check_eq("hold_addr_err", addr_err, 0);
        check_eq("hold_key_valid_end", key_valid, 1'b1);
        check_sched("hold");

        // Asynchronous reset mid-expansion, then a fresh expansion
        clear_mon();
        start_exp({128{1'b1}});
        repeat (14) tick();
        check_eq("prerst_wr_en", wr_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_wr_en", wr_en, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_done", done, 1'b0);
        check_eq("arst_key_valid", key_valid, 1'b0);
        check_eq("arst_wraddr", wraddr, 5'd0);
        tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        build_model(STD_KEY);
        start_exp(STD_KEY);
        wait_done(1, 60);
        check_eq("postrst_first_wr_lat", first_wr - e0, 1);
        check_eq("postrst_wr_total", wr_total, 32);
        check_eq("postrst_addr_err", addr_err, 0);
        check_eq("postrst_rk0", ram[0], 32'hF12186F9);
        check_sched("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
